// File: rtl/uart_stim_tx.sv
// Bench-side stimulus source: sequences the DUT reset after rst drops, then
// serialises bytes from a small FIFO onto a UART line with a configurable frame.
module uart_stim_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16,
  parameter int RST_HOLD_CYCLES = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          dut_rst,
  output logic                          txd,
  output logic                          busy,
  output logic                          byte_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int RW = $clog2(RST_HOLD_CYCLES + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(RST_HOLD_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 dut_rst_q, dut_rst_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic push, pop, baud_last;
  logic [DATA_BITS-1:0] head;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign head      = mem[rptr_q];
  assign push      = wr_en && !full_q;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_d     = par_q;
    txd_d     = txd_q;
    dut_rst_d = dut_rst_q;
    rcnt_d    = rcnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    pop       = 1'b0;

    if (dut_rst_q) begin
      rcnt_d = rcnt_q + RW'(1);
      if (rcnt_q == HOLD_LAST) dut_rst_d = 1'b0;
    end

    if (state_q != S_IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (level_q != '0 && !dut_rst_q) pop = 1'b1;
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + CW'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (PARITY != 0) begin
            state_d = S_PARITY;
            txd_d   = par_q;
          end else begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            txd_d   = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (stop_q != STOP_LAST) begin
            stop_d = 1'b1;
          end else if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Popping a byte always starts a fresh frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      txd_d   = 1'b0;
      shift_d = head;
      par_d   = parity_bit(head);
      rptr_d  = rptr_q + AW'(1);
    end

    if (push) wptr_d = wptr_q + AW'(1);
    if (wr_en && full_q) ovf_d = 1'b1;
    level_d = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
    full_d  = (level_d == DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      txd_q     <= 1'b1;
      dut_rst_q <= 1'b1;
      rcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      txd_q     <= txd_d;
      dut_rst_q <= dut_rst_d;
      rcnt_q    <= rcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push) mem[wptr_q] <= wr_data;
  end

  assign full      = full_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign dut_rst   = dut_rst_q;
  assign txd       = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign byte_done = (state_q == S_STOP) && baud_last && (stop_q == STOP_LAST);
endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: four instances cover plain, odd parity,
// even parity with two stop bits, and a shallow FIFO with a long reset hold.
module tb_uart_stim_tx;
  localparam int CPB = 4;
  localparam int NI  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NI-1:0]   wr_en;
  logic [7:0]      wr_data [NI];
  logic [NI-1:0]   full, overflow, dut_rst, txd, busy, byte_done;
  logic [4:0]      level0, level1, level2;
  logic [2:0]      level3;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb0[$], sb1[$], sb2[$], sb3[$];

  uart_stim_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .RST_HOLD_CYCLES(10)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]),
    .level(level0), .overflow(overflow[0]), .dut_rst(dut_rst[0]), .txd(txd[0]),
    .busy(busy[0]), .byte_done(byte_done[0]));
  uart_stim_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .RST_HOLD_CYCLES(10)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]),
    .level(level1), .overflow(overflow[1]), .dut_rst(dut_rst[1]), .txd(txd[1]),
    .busy(busy[1]), .byte_done(byte_done[1]));
  uart_stim_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(16), .RST_HOLD_CYCLES(10)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .full(full[2]),
    .level(level2), .overflow(overflow[2]), .dut_rst(dut_rst[2]), .txd(txd[2]),
    .busy(busy[2]), .byte_done(byte_done[2]));
  uart_stim_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .RST_HOLD_CYCLES(200)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .full(full[3]),
    .level(level3), .overflow(overflow[3]), .dut_rst(dut_rst[3]), .txd(txd[3]),
    .busy(busy[3]), .byte_done(byte_done[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int s);
    case (s)
      0: return 32'(level0);
      1: return 32'(level1);
      2: return 32'(level2);
      default: return 32'(level3);
    endcase
  endfunction

  function automatic int sb_size(input int s);
    case (s)
      0: return sb0.size();
      1: return sb1.size();
      2: return sb2.size();
      default: return sb3.size();
    endcase
  endfunction

  function automatic logic [7:0] sb_pop(input int s);
    case (s)
      0: return sb0.pop_front();
      1: return sb1.pop_front();
      2: return sb2.pop_front();
      default: return sb3.pop_front();
    endcase
  endfunction

  task automatic sb_push(input int s, input logic [7:0] b);
    case (s)
      0: sb0.push_back(b);
      1: sb1.push_back(b);
      2: sb2.push_back(b);
      default: sb3.push_back(b);
    endcase
  endtask

  // Waits (bounded) for a start bit on instance s, then checks every cycle of the frame.
  task automatic check_frame(input int s, input int pmode, input int nstop,
                             input int max_wait, input string tag);
    int w;
    int ones;
    int len;
    logic [7:0] b;
    logic bits[$];
    w = 0;
    while (txd[s] !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start"}, 32'(txd[s]), 32'd0);
    if (txd[s] !== 1'b0) return;
    chk({tag, "_sb_nonempty"}, 32'(sb_size(s) > 0), 32'd1);
    if (sb_size(s) == 0) return;
    b = sb_pop(s);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (pmode == 1) bits.push_back((ones % 2) == 0);
    if (pmode == 2) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    len = bits.size() * CPB;
    for (int c = 0; c < len; c++) begin
      chk($sformatf("%s_txd_c%0d", tag, c), 32'(txd[s]), 32'(bits[c / CPB]));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(byte_done[s]), 32'(c == len - 1));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy[s]), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = '0;
    for (int s = 0; s < NI; s++) wr_data[s] = 8'h00;
    repeat (5) @(negedge clk);

    for (int s = 0; s < NI; s++) begin
      chk($sformatf("rst_txd%0d", s), 32'(txd[s]), 32'd1);
      chk($sformatf("rst_dutrst%0d", s), 32'(dut_rst[s]), 32'd1);
      chk($sformatf("rst_full%0d", s), 32'(full[s]), 32'd0);
      chk($sformatf("rst_level%0d", s), lvl(s), 32'd0);
      chk($sformatf("rst_ovf%0d", s), 32'(overflow[s]), 32'd0);
      chk($sformatf("rst_busy%0d", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst_done%0d", s), 32'(byte_done[s]), 32'd0);
    end

    // Release rst; load u0 with 3 bytes and u3 with 6 bytes while dut_rst is still high.
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wr_en[0] = (i <= 3);
      wr_en[3] = (i <= 6);
      wr_data[0] = (i == 1) ? 8'h3C : (i == 2) ? 8'h81 : 8'h5A;
      wr_data[3] = 8'(8'h11 * i);
      if (i <= 3) sb_push(0, wr_data[0]);
      if (i <= 4) sb_push(3, wr_data[3]);
      @(negedge clk);
      chk($sformatf("hold_dutrst0_e%0d", i), 32'(dut_rst[0]), 32'(i < 10));
      chk($sformatf("hold_dutrst3_e%0d", i), 32'(dut_rst[3]), 32'd1);
      chk($sformatf("hold_txd0_e%0d", i), 32'(txd[0]), 32'd1);
      chk($sformatf("hold_busy0_e%0d", i), 32'(busy[0]), 32'd0);
      chk($sformatf("hold_txd3_e%0d", i), 32'(txd[3]), 32'd1);
    end
    wr_en = '0;
    chk("gated_level0", lvl(0), 32'd3);
    chk("ovf_full3", 32'(full[3]), 32'd1);
    chk("ovf_level3", lvl(3), 32'd4);
    chk("ovf_flag3", 32'(overflow[3]), 32'd1);
    chk("no_ovf0", 32'(overflow[0]), 32'd0);

    check_frame(0, 0, 1, 1, "b2b0");
    check_frame(0, 0, 1, 0, "b2b1");
    check_frame(0, 0, 1, 0, "b2b2");
    chk("b2b_level_end", lvl(0), 32'd0);
    chk("b2b_busy_end", 32'(busy[0]), 32'd0);
    chk("b2b_txd_end", 32'(txd[0]), 32'd1);

    check_frame(3, 0, 1, 100, "ovf0");
    for (int k = 1; k < 4; k++) check_frame(3, 0, 1, 0, $sformatf("ovf%0d", k));
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("ovf_idle_txd_c%0d", c), 32'(txd[3]), 32'd1);
      @(negedge clk);
    end
    chk("ovf_level_end", lvl(3), 32'd0);
    chk("ovf_sticky", 32'(overflow[3]), 32'd1);

    // Single byte: start bit one cycle after level first reads nonzero.
    wr_en[0] = 1'b1; wr_data[0] = 8'hA5; sb_push(0, 8'hA5);
    @(negedge clk);
    wr_en[0] = 1'b0;
    chk("a5_level1", lvl(0), 32'd1);
    chk("a5_txd_pre", 32'(txd[0]), 32'd1);
    @(negedge clk);
    check_frame(0, 0, 1, 0, "a5");
    chk("a5_busy_end", 32'(busy[0]), 32'd0);

    wr_en[1] = 1'b1; wr_data[1] = 8'h03; sb_push(1, 8'h03);
    @(negedge clk);
    wr_en[1] = 1'b0;
    @(negedge clk);
    check_frame(1, 1, 1, 0, "odd03");
    chk("odd_busy_end", 32'(busy[1]), 32'd0);

    wr_en[2] = 1'b1; wr_data[2] = 8'h03; sb_push(2, 8'h03);
    @(negedge clk);
    wr_en[2] = 1'b0;
    @(negedge clk);
    check_frame(2, 2, 2, 0, "even03");
    chk("even_busy_end", 32'(busy[2]), 32'd0);
    chk("even_txd_end", 32'(txd[2]), 32'd1);

    // Abort mid-DATA of 8'hFF with two more bytes queued behind it.
    wr_en[0] = 1'b1; wr_data[0] = 8'hFF;
    @(negedge clk);
    wr_data[0] = 8'h11;
    @(negedge clk);
    chk("abort_start", 32'(txd[0]), 32'd0);
    wr_data[0] = 8'h22;
    @(negedge clk);
    wr_en[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_pre_txd", 32'(txd[0]), 32'd1);
    chk("abort_pre_busy", 32'(busy[0]), 32'd1);
    chk("abort_pre_level", lvl(0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_txd", 32'(txd[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_level", lvl(0), 32'd0);
    chk("abort_dutrst", 32'(dut_rst[0]), 32'd1);
    chk("abort_ovf3", 32'(overflow[3]), 32'd0);
    chk("abort_full3", 32'(full[3]), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("reseq_dutrst_e%0d", i), 32'(dut_rst[0]), 32'(i < 10));
      chk($sformatf("reseq_txd_e%0d", i), 32'(txd[0]), 32'd1);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort_txd_c%0d", c), 32'(txd[0]), 32'd1);
      chk($sformatf("post_abort_busy_c%0d", c), 32'(busy[0]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
